// File: rtl/regfile_mp_sb_pkg.sv
// Shared register-file constants and helpers, also used by decode and writeback.
package regfile_mp_sb_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;

  // When both writeback ports target one register, port A's data is kept.
  localparam bit PORT_A_WINS = 1'b1;

  function automatic int depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One read port: storage mux, same-cycle write bypass and scoreboard status.
module regfile_rd_port
  import regfile_mp_sb_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int ZERO_R0 = 0,
  parameter int BYPASS  = 1
) (
  input  logic [ADDR_W-1:0]      i_addr,
  input  logic [DATA_W-1:0]      i_regs [depth(ADDR_W)],
  input  logic [depth(ADDR_W)-1:0] i_busy,
  input  logic                   i_wa_en,
  input  logic [ADDR_W-1:0]      i_wa_addr,
  input  logic [DATA_W-1:0]      i_wa_data,
  input  logic                   i_wb_en,
  input  logic [ADDR_W-1:0]      i_wb_addr,
  input  logic [DATA_W-1:0]      i_wb_data,
  output logic [DATA_W-1:0]      o_data,
  output logic                   o_busy
);

  logic w_hit_a;
  logic w_hit_b;
  logic w_is_zero;

  assign w_hit_a   = i_wa_en && (i_wa_addr == i_addr);
  assign w_hit_b   = i_wb_en && (i_wb_addr == i_addr);
  assign w_is_zero = (ZERO_R0 != 0) && (i_addr == '0);

  always_comb begin
    // NOTE: o_data gets its default first so no path through this block can infer a latch.
    o_data = i_regs[i_addr];
    if (BYPASS != 0) begin
      if (PORT_A_WINS) begin
        if (w_hit_a)      o_data = i_wa_data;
        else if (w_hit_b) o_data = i_wb_data;
      end else begin
        if (w_hit_b)      o_data = i_wb_data;
        else if (w_hit_a) o_data = i_wa_data;
      end
    end
    if (w_is_zero) o_data = '0;
  end

  // A forwarded result makes the register usable this cycle even though busy is still set.
  assign o_busy = i_busy[i_addr] && !((BYPASS != 0) && (w_hit_a || w_hit_b));

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with two writeback ports, bypass and busy scoreboard.
module regfile_mp_sb
  import regfile_mp_sb_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NUM_RD  = 2,
  parameter int ZERO_R0 = 0,
  parameter int BYPASS  = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_RD*ADDR_W-1:0]   i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   o_rd_data,
  output logic [NUM_RD-1:0]          o_rd_busy,
  input  logic                       i_wa_en,
  input  logic [ADDR_W-1:0]          i_wa_addr,
  input  logic [DATA_W-1:0]          i_wa_data,
  input  logic                       i_wb_en,
  input  logic [ADDR_W-1:0]          i_wb_addr,
  input  logic [DATA_W-1:0]          i_wb_data,
  input  logic                       i_iss_en,
  input  logic [ADDR_W-1:0]          i_iss_addr,
  output logic                       o_hazard,
  output logic [depth(ADDR_W)-1:0]   o_busy_vec
);

  localparam int DEPTH = depth(ADDR_W);

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [DEPTH-1:0]  w_we_a;
  logic [DEPTH-1:0]  w_we_b;
  logic [DEPTH-1:0]  w_set;

  for (genvar g = 0; g < DEPTH; g++) begin : g_dec
    localparam bit IS_ZERO = (ZERO_R0 != 0) && (g == 0);
    assign w_we_a[g] = i_wa_en  && (i_wa_addr  == ADDR_W'(g)) && !IS_ZERO;
    assign w_we_b[g] = i_wb_en  && (i_wb_addr  == ADDR_W'(g)) && !IS_ZERO;
    assign w_set[g]  = i_iss_en && (i_iss_addr == ADDR_W'(g)) && !IS_ZERO;
  end

  // NOTE: the storage array is reset on purpose: software relies on every register reading 0 after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_we_a[i] && (PORT_A_WINS || !w_we_b[i])) r_regs[i] <= i_wa_data;
        else if (w_we_b[i])                             r_regs[i] <= i_wb_data;
      end
    end
  end

  // Issue beats a same-cycle writeback: the new producer supersedes the retiring one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_busy <= '0;
    else       r_busy <= w_set | (r_busy & ~(w_we_a | w_we_b));
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .ZERO_R0(ZERO_R0),
      .BYPASS (BYPASS)
    ) u_rd_port (
      .i_addr   (i_rd_addr[k*ADDR_W +: ADDR_W]),
      .i_regs   (r_regs),
      .i_busy   (r_busy),
      .i_wa_en  (i_wa_en),
      .i_wa_addr(i_wa_addr),
      .i_wa_data(i_wa_data),
      .i_wb_en  (i_wb_en),
      .i_wb_addr(i_wb_addr),
      .i_wb_data(i_wb_data),
      .o_data   (o_rd_data[k*DATA_W +: DATA_W]),
      .o_busy   (o_rd_busy[k])
    );
  end

  assign o_hazard   = |o_rd_busy;
  assign o_busy_vec = r_busy;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Randomised bench for regfile_mp_sb over three configurations against an array model.
module tb_regfile_mp_sb;

  logic        clock = 1'b0;
  logic        reset;
  logic [8:0]  rd_addr;
  logic        wa_en, wb_en, iss_en;
  logic [2:0]  wa_addr, wb_addr, iss_addr;
  logic [15:0] wa_data, wb_data;

  // config 0: defaults; config 1: ZERO_R0=1; config 2: BYPASS=0, three read ports
  logic [31:0] rd_data0, rd_data1;
  logic [47:0] rd_data2;
  logic [1:0]  rd_busy0, rd_busy1;
  logic [2:0]  rd_busy2;
  logic        hazard0, hazard1, hazard2;
  logic [7:0]  busy_vec0, busy_vec1, busy_vec2;

  int n_vec  = 0;
  int n_miss = 0;

  logic [15:0] m_reg  [3][8];
  bit          m_busy [3][8];

  always #5 clock = ~clock;

  regfile_mp_sb u_dut0 (
    .clock(clock), .reset(reset), .i_rd_addr(rd_addr[5:0]), .o_rd_data(rd_data0),
    .o_rd_busy(rd_busy0), .i_wa_en(wa_en), .i_wa_addr(wa_addr), .i_wa_data(wa_data),
    .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data), .i_iss_en(iss_en),
    .i_iss_addr(iss_addr), .o_hazard(hazard0), .o_busy_vec(busy_vec0));

  regfile_mp_sb #(.ZERO_R0(1)) u_dut1 (
    .clock(clock), .reset(reset), .i_rd_addr(rd_addr[5:0]), .o_rd_data(rd_data1),
    .o_rd_busy(rd_busy1), .i_wa_en(wa_en), .i_wa_addr(wa_addr), .i_wa_data(wa_data),
    .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data), .i_iss_en(iss_en),
    .i_iss_addr(iss_addr), .o_hazard(hazard1), .o_busy_vec(busy_vec1));

  regfile_mp_sb #(.NUM_RD(3), .BYPASS(0)) u_dut2 (
    .clock(clock), .reset(reset), .i_rd_addr(rd_addr), .o_rd_data(rd_data2),
    .o_rd_busy(rd_busy2), .i_wa_en(wa_en), .i_wa_addr(wa_addr), .i_wa_data(wa_data),
    .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data), .i_iss_en(iss_en),
    .i_iss_addr(iss_addr), .o_hazard(hazard2), .o_busy_vec(busy_vec2));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_data(input int c, input int a);
    bit zr  = (c == 1);
    bit byp = (c != 2);
    if (zr && a == 0) return 16'h0;
    if (byp && wa_en && int'(wa_addr) == a) return wa_data;
    if (byp && wb_en && int'(wb_addr) == a) return wb_data;
    return m_reg[c][a];
  endfunction

  function automatic bit exp_busy(input int c, input int a);
    bit byp = (c != 2);
    bit wr  = (wa_en && int'(wa_addr) == a) || (wb_en && int'(wb_addr) == a);
    return m_busy[c][a] && !(byp && wr);
  endfunction

  function automatic logic [15:0] got_data(input int c, input int k);
    case (c)
      0:       return rd_data0[k*16 +: 16];
      1:       return rd_data1[k*16 +: 16];
      default: return rd_data2[k*16 +: 16];
    endcase
  endfunction

  function automatic logic got_busy(input int c, input int k);
    case (c)
      0:       return rd_busy0[k];
      1:       return rd_busy1[k];
      default: return rd_busy2[k];
    endcase
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 3; c++)
      for (int i = 0; i < 8; i++) begin
        m_reg[c][i]  = 16'h0;
        m_busy[c][i] = 1'b0;
      end
  endtask

  task automatic model_commit();
    for (int c = 0; c < 3; c++) begin
      bit zr = (c == 1);
      if (wb_en && !(zr && wb_addr == 3'd0)) m_reg[c][wb_addr] = wb_data;
      if (wa_en && !(zr && wa_addr == 3'd0)) m_reg[c][wa_addr] = wa_data;
      for (int i = 0; i < 8; i++) begin
        if ((wa_en && int'(wa_addr) == i) || (wb_en && int'(wb_addr) == i)) m_busy[c][i] = 1'b0;
        if (iss_en && int'(iss_addr) == i && !(zr && i == 0))               m_busy[c][i] = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < 3; c++) begin
      int          nr = (c == 2) ? 3 : 2;
      bit          hz = 1'b0;
      logic [7:0]  bv;
      logic        got_hz;
      logic [7:0]  got_bv;
      for (int k = 0; k < nr; k++) begin
        int a = int'(rd_addr[k*3 +: 3]);
        check($sformatf("c%0d rd_data[%0d] a=%0d", c, k, a), 64'(got_data(c, k)), 64'(exp_data(c, a)));
        check($sformatf("c%0d rd_busy[%0d] a=%0d", c, k, a), 64'(got_busy(c, k)), 64'(exp_busy(c, a)));
        hz |= exp_busy(c, a);
      end
      for (int i = 0; i < 8; i++) bv[i] = m_busy[c][i];
      got_hz = (c == 0) ? hazard0 : (c == 1) ? hazard1 : hazard2;
      got_bv = (c == 0) ? busy_vec0 : (c == 1) ? busy_vec1 : busy_vec2;
      check($sformatf("c%0d hazard", c), 64'(got_hz), 64'(hz));
      check($sformatf("c%0d busy_vec", c), 64'(got_bv), 64'(bv));
    end
  endtask

  task automatic idle();
    wa_en = 1'b0; wb_en = 1'b0; iss_en = 1'b0;
    wa_addr = '0; wb_addr = '0; iss_addr = '0;
    wa_data = '0; wb_data = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    if (!reset) model_commit();
    #1;
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    rd_addr = '0;
    idle();
    model_clear();
    tick(); tick();
    reset = 1'b0;

    for (int a = 0; a < 8; a++) begin
      rd_addr = {3'(a), 3'(a), 3'(7 - a)};
      #1;
      check("reset rd_data0", 64'(rd_data0), 64'h0);
      check_all();
    end

    wa_en = 1'b1; wa_addr = 3'd3; wa_data = 16'h1234;
    #1 check_all();
    tick();
    idle(); rd_addr = 9'({3'd0, 3'd0, 3'd3});
    #1 check("write A addr3", 64'(rd_data0[15:0]), 64'h1234);
    check_all();

    wa_en = 1'b1; wa_addr = 3'd5; wa_data = 16'hAAAA;
    wb_en = 1'b1; wb_addr = 3'd5; wb_data = 16'h5555;
    rd_addr = 9'({3'd0, 3'd0, 3'd5});
    #1 check("bypass A wins", 64'(rd_data0[15:0]), 64'hAAAA);
    check_all();
    tick();
    idle();
    #1 check("stored A wins", 64'(rd_data0[15:0]), 64'hAAAA);
    check_all();

    iss_en = 1'b1; iss_addr = 3'd2;
    tick();
    idle(); rd_addr = 9'({3'd0, 3'd2, 3'd3});
    #1 check("rd_busy[1] after issue", 64'(rd_busy0[1]), 64'h1);
    check("hazard after issue", 64'(hazard0), 64'h1);
    check_all();
    wb_en = 1'b1; wb_addr = 3'd2; wb_data = 16'h00FF;
    #1 check("rd_busy[1] bypassed", 64'(rd_busy0[1]), 64'h0);
    check("rd_data[1] bypassed", 64'(rd_data0[31:16]), 64'h00FF);
    check_all();
    tick();
    idle();
    #1 check("busy_vec[2] cleared", 64'(busy_vec0[2]), 64'h0);
    check_all();

    iss_en = 1'b1; iss_addr = 3'd4;
    wa_en = 1'b1; wa_addr = 3'd4; wa_data = 16'h0001;
    tick();
    idle(); rd_addr = 9'({3'd0, 3'd0, 3'd4});
    #1 check("set beats clear", 64'(busy_vec0[4]), 64'h1);
    check("reg4 value", 64'(rd_data0[15:0]), 64'h0001);
    check_all();

    wa_en = 1'b1; wa_addr = 3'd0; wa_data = 16'hFFFF;
    iss_en = 1'b1; iss_addr = 3'd0;
    rd_addr = '0;
    #1 check("zero r0 no bypass", 64'(rd_data1[15:0]), 64'h0);
    check("plain r0 bypass", 64'(rd_data0[15:0]), 64'hFFFF);
    check_all();
    tick();
    idle();
    #1 check("zero r0 after write", 64'(rd_data1[15:0]), 64'h0);
    check("zero r0 never busy", 64'(busy_vec1[0]), 64'h0);
    check_all();

    wa_en = 1'b1; wa_addr = 3'd7; wa_data = 16'hBEEF;
    tick();
    idle(); iss_en = 1'b1; iss_addr = 3'd1;
    tick();
    idle(); rd_addr = 9'({3'd7, 3'd1, 3'd7});
    #1 check("reg7 before reset", 64'(rd_data0[15:0]), 64'hBEEF);
    #1 reset = 1'b1;
    model_clear();
    #1 check("async reset data", 64'(rd_data0), 64'h0);
    check("async reset busy_vec", 64'(busy_vec0), 64'h0);
    check_all();
    wa_en = 1'b1; wa_addr = 3'd7; wa_data = 16'h1111; iss_en = 1'b1; iss_addr = 3'd7;
    tick();
    idle();
    reset = 1'b0;
    #1 check("write during reset dropped", 64'(rd_data0[15:0]), 64'h0);
    check_all();

    for (int n = 0; n < 400; n++) begin
      rd_addr  = 9'($urandom);
      wa_en    = 1'($urandom);
      wb_en    = 1'($urandom);
      iss_en   = 1'($urandom);
      wa_addr  = 3'($urandom);
      wb_addr  = 3'($urandom_range(0, 3) == 0 ? int'(wa_addr) : int'($urandom));
      iss_addr = 3'($urandom);
      wa_data  = 16'($urandom);
      wb_data  = 16'($urandom);
      #1 check_all();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port general-purpose register file for the next-generation pipelined datapath.
- Successor to the single-write, two-read 8x16 file. Generalises data width, depth and read-port count.
- Adds a second write port, write-to-read bypass, an optional hard-wired zero register, and a per-register busy scoreboard.
- Sits between decode/issue (read ports, issue/scoreboard set) and writeback (ALU port A, load port B).

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers.
- NUM_RD, 2, number of independent read ports (1..4).
- ZERO_R0, 0, when 1 register 0 always reads 0, ignores writes and is never busy.
- BYPASS, 1, when 1 same-cycle write data is forwarded to matching read ports.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  reset, asynchronous, active-high.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W].
- rd_busy  out  NUM_RD  scoreboard status of each read port's register.
- wa_en  in  1  write port A (ALU writeback) enable.
- wa_addr  in  ADDR_W  write port A address.
- wa_data  in  DATA_W  write port A data.
- wb_en  in  1  write port B (load writeback) enable.
- wb_addr  in  ADDR_W  write port B address.
- wb_data  in  DATA_W  write port B data.
- iss_en  in  1  issue: mark iss_addr busy (pending result).
- iss_addr  in  ADDR_W  destination register of the issuing instruction.
- hazard  out  1  OR over read ports of rd_busy.
- busy_vec  out  DEPTH  raw scoreboard bits, for debug.

Behaviour:
- Reset (async, while high): all DEPTH registers are 0 and all busy bits are 0. Hence rd_data=0, rd_busy=0, hazard=0, busy_vec=0.
- Writes:
  - Take effect on the rising clock edge when the enable is high. Stored value is visible on rd_data the next cycle.
  - Both ports to different addresses: both commit.
  - Both ports to the same address: port A wins, port B's data is discarded.
- Reads: combinational, zero latency; rd_data[k] = reg[rd_addr[k]].
- Bypass (BYPASS=1):
  - If wa_en && wa_addr==rd_addr[k], rd_data[k] = wa_data.
  - Otherwise, if wb_en && wb_addr==rd_addr[k], rd_data[k] = wb_data.
  - Port A takes priority, consistent with write priority.
  - With BYPASS=0, reads return the pre-edge stored value.
- Scoreboard:
  - busy[i] is set at the edge when iss_en && iss_addr==i.
  - busy[i] is cleared at the edge when (wa_en && wa_addr==i) or (wb_en && wb_addr==i).
  - Set and clear on the same register in the same cycle: set wins. The new issue supersedes the retiring writeback; busy stays 1.
  - Issue to an already-busy register keeps busy=1 (no counting; the pipeline guarantees in-order WAW).
- rd_busy[k]:
  - BYPASS=1: busy[rd_addr[k]] && !(a write to rd_addr[k] is enabled this cycle). Forwarded data is valid.
  - BYPASS=0: busy[rd_addr[k]].
- hazard = |rd_busy, combinational.
- ZERO_R0=1:
  - Writes to address 0 are ignored. Reads of address 0 return 0, including when a port writes address 0 that cycle (no bypass).
  - Issue to address 0 is ignored; busy[0] stays 0.
- Reset asserted mid-operation discards pending writes and issues in that cycle. Scoreboard is cleared, so in-flight results are lost; the pipeline flushes on reset.
- All address arithmetic is exact ADDR_W bits; no out-of-range addresses exist.

Decomposition:
- Shared package: DATA_W/ADDR_W defaults and a DEPTH function (2**ADDR_W), also used by decode and writeback.
- Shared package: write-port priority constant (PORT_A_WINS).
- One natural sub-module, regfile_rd_port: one read mux with bypass compare and rd_busy logic. Instantiate it NUM_RD times in a generate loop.
- Storage and scoreboard stay in the top module.

Test Plan:
- Reset then read all addresses -> every rd_data=0, busy_vec=0, hazard=0. Write A addr 3=16'h1234 -> next cycle rd_addr[0]=3 returns 16'h1234.
- Same cycle wa_en addr5=16'hAAAA and wb_en addr5=16'h5555 -> stored 16'hAAAA. The bypass read of addr5 in that same cycle shows 16'hAAAA.
- iss_en addr2 -> next cycle rd_addr[1]=2 gives rd_busy[1]=1, hazard=1. Then wb_en addr2=16'h00FF -> that cycle rd_busy[1]=0, rd_data[1]=16'h00FF (bypass); next cycle busy_vec[2]=0.
- iss_en addr4 and wa_en addr4=16'h0001 in the same cycle -> busy_vec[4]=1 afterwards; reg4=16'h0001.
- ZERO_R0=1: wa_en addr0=16'hFFFF plus iss_en addr0 -> rd_data for addr0=0 in that cycle and after; busy_vec[0]=0.
- Write reg7=16'hBEEF, issue addr1, then assert reset mid-cycle asynchronously -> rd_data immediately 0, busy_vec=0 before the next edge.
